life_ctrl: RTL and testbench
============================

# life_ctrl

Generation controller sitting directly upstream of the 16×16 Life update stage. It owns the current board register and drives it into the update stage's `board_input`. It captures the stage's `board_output` once per generation tick while running. While paused it lets the user edit cells through a cursor, single-step one generation, or clear the board.

## Interface
Parameters:
- `TICK_DIV`, default 25_000_000: clock cycles per generation while running. Must be ≥ 4.
- `SETTLE_CYCLES`, default 2: cycles the board is held before `next_board` is captured. Must be ≥ 1.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each: single-cycle cursor move pulses, already debounced.
- `btn_toggle`  in  1: pulse; inverts the cell under the cursor.
- `btn_step`  in  1: pulse; performs exactly one generation while paused.
- `btn_run`  in  1: pulse; toggles between run and pause.
- `btn_clear`  in  1: pulse; zeroes the board and the generation count.
- `next_board`  in  256: update-stage output.
- `board_q`  out  256: current board, fed to the update stage input. Bit index = row*16 + col.
- `cursor`  out  8: cursor cell index, row*16 + col.
- `running`  out  1: high in RUN, SETTLE_RUN and COMMIT-from-run.
- `gen_count`  out  16: generations committed since reset or clear.
- `stable`  out  1: still-life flag (see Configuration).

## Operation
- States: PAUSED, RUN, SETTLE, COMMIT. `running` is derived from a `run_mode` flag, not from the state alone.
- **Reset:** applies in all states, including mid-SETTLE.
  - `board_q` = 0, `cursor` = 0, `gen_count` = 0, `stable` = 0.
  - `run_mode` = 0, state = PAUSED, tick counter = 0.
- **Action priority:** at most one button action is taken per cycle, in this order: clear > run > step > toggle > up > down > left > right. Lower-priority pulses in the same cycle are dropped.
- **PAUSED:**
  - toggle: `board_q[cursor]` inverts.
  - up: row−1. down: row+1. left: col−1. right: col+1. Each axis wraps modulo 16, e.g. col 15 + right → col 0 on the same row.
  - step: → SETTLE with `run_mode` = 0.
  - run: `run_mode` = 1, tick counter = 0 → RUN.
- **RUN:**
  - The tick counter counts 0..TICK_DIV−1.
  - When the counter is at TICK_DIV−1 → SETTLE, and the counter returns to 0.
  - run: `run_mode` = 0 → PAUSED.
  - Toggle, step and move are ignored.
- **SETTLE:**
  - `board_q` is held for SETTLE_CYCLES cycles, then → COMMIT.
  - A run pulse here sets `pause_pending`. All edit pulses are ignored.
- **COMMIT** (one cycle):
  - `board_q` ← `next_board`; `gen_count` += 1, wrapping 65535 → 0.
  - If `run_mode` = 1 and `pause_pending` = 0 → RUN. Otherwise → PAUSED with `run_mode` = 0.
  - `pause_pending` clears.
- **Clear:** accepted in any state. `board_q` = 0, `gen_count` = 0, `stable` = 0, `run_mode` = 0, `pause_pending` = 0, → PAUSED. `cursor` is unchanged.

## Timing
- The update stage is registered: `next_board` reflects `board_q` one cycle late. SETTLE_CYCLES ≥ 1 guarantees the capture sees the settled value.
- Step latency: the step pulse is at cycle t. The state is SETTLE for t+1..t+SETTLE_CYCLES, COMMIT at t+SETTLE_CYCLES+1, and the new `board_q` is visible at t+SETTLE_CYCLES+2. With defaults, the new board appears 4 cycles after the pulse.
- Run period: one generation every TICK_DIV + SETTLE_CYCLES + 1 cycles.
- Edit latency: a toggle or move pulse at cycle t is visible on `board_q` or `cursor` at t+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `LIFE_CTRL_AUTOPAUSE_EN` defined:
  - In COMMIT, if `next_board` == `board_q`, then `stable` = 1 and the FSM goes → PAUSED with `run_mode` = 0. `gen_count` still increments.
  - `stable` clears on clear, toggle, or any COMMIT whose board changes.
- `LIFE_CTRL_AUTOPAUSE_EN` undefined:
  - `stable` is tied to 0, with no comparator logic.
  - A still life keeps running indefinitely.

## Structure
- **Package `life_pkg`:**
  - `BOARD_DIM` = 16 and `BOARD_CELLS` = 256.
  - The `ctrl_state_t` enum (PAUSED, RUN, SETTLE, COMMIT).
  - Cursor row/col helper functions with wrap.
- **Sub-module `life_tick_gen`:**
  - Parameter TICK_DIV; counter width `$clog2(TICK_DIV)`.
  - Inputs `enable` and `restart`; output `tick`, a single-cycle pulse at count TICK_DIV−1.

## Test plan
- **Blinker run:** TICK_DIV = 4, autopause off. Toggle cells 17, 18, 19, then run. The first COMMIT gives cells {2, 18, 34}, `gen_count` = 1; the next gives {17, 18, 19}, `gen_count` = 2. The period is 7 cycles.
- **Cursor wrap:** from reset, left → cursor 15; up → 255; right → 240; down → 0.
- **Step with simultaneous buttons:** paused, step and toggle pulsed in the same cycle. Step wins, the toggle is dropped, and `board_q` changes 4 cycles later.
- **Pause during SETTLE:** run pulse during SETTLE. COMMIT still happens, then PAUSED with `running` = 0.
- **Clear mid-run:** clear during RUN. Next cycle: `board_q` = 0, `gen_count` = 0, PAUSED. A later reset mid-SETTLE gives all outputs zero on the following cycle.
- **Autopause (macro on):** 2×2 block at cells 17, 18, 33, 34, then run. The first COMMIT sets `stable` = 1, `running` = 0, `gen_count` = 1.

Source files
------------

// File: rtl/life_pkg.sv
// Shared definitions for the Life generation controller: board geometry,
// controller state encoding and cursor arithmetic helpers.
package life_pkg;

    localparam int BOARD_DIM   = 16;
    localparam int BOARD_CELLS = 256;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2,
        COMMIT = 2'd3
    } ctrl_state_t;

    // Cursor index layout is {row[3:0], col[3:0]} = row*16 + col.
    function automatic logic [3:0] cursor_row(input logic [7:0] cur);
        return cur[7:4];
    endfunction

    function automatic logic [3:0] cursor_col(input logic [7:0] cur);
        return cur[3:0];
    endfunction

    // Moves the cursor by a 4-bit two's-complement delta per axis; the 4-bit
    // additions wrap each axis modulo 16 independently.
    function automatic logic [7:0] cursor_step(input logic [7:0] cur,
                                               input logic [3:0] drow,
                                               input logic [3:0] dcol);
        logic [3:0] row;
        logic [3:0] col;
        row = cursor_row(cur) + drow;
        col = cursor_col(cur) + dcol;
        return {row, col};
    endfunction

endpackage

// File: rtl/life_tick_gen.sv
// Generation tick divider: counts 0..TICK_DIV-1 while enabled and emits a
// single-cycle tick on the last count, then wraps to 0. restart forces the
// count back to 0 so a fresh run always gets a full period.
module life_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    // Period counter, frozen while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/life_ctrl.sv
// Generation controller for the 16x16 Life update stage. Owns the board
// register, runs/steps generations and lets the user edit cells while paused.
// Optional feature macro: LIFE_CTRL_AUTOPAUSE_EN (still-life detection that
// sets `stable` and drops back to PAUSED).
// All btn_* inputs are single-cycle pulses; a pulse is consumed on the clock
// edge where it is high, and at most one of them acts per cycle.
module life_ctrl
    import life_pkg::*;
#(
    parameter int TICK_DIV      = 25_000_000,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_toggle,
    input  logic                   btn_step,
    input  logic                   btn_run,
    input  logic                   btn_clear,
    input  logic [BOARD_CELLS-1:0] next_board,
    output logic [BOARD_CELLS-1:0] board_q,
    output logic [7:0]             cursor,
    output logic                   running,
    output logic [15:0]            gen_count,
    output logic                   stable,
    output ctrl_state_t            state_dbg
);

    localparam int            SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    ctrl_state_t            state, state_nx;
    logic [BOARD_CELLS-1:0] board_nx;
    logic [7:0]             cursor_nx;
    logic [15:0]            gen_nx;
    logic                   run_mode, run_nx;
    logic                   pause_pending, pp_nx;
    logic [SW-1:0]          settle_cnt, settle_nx;
    logic                   restart;
    logic                   tick;
    logic                   still;
`ifdef LIFE_CTRL_AUTOPAUSE_EN
    logic                   stable_r, stable_nx;
`endif

    life_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .enable  (state == RUN),
        .restart (restart),
        .tick    (tick)
    );

    // Next-state and next-register values; clear overrides everything, then
    // each state applies the highest-priority pulse it honours.
    always_comb begin
        state_nx  = state;
        board_nx  = board_q;
        cursor_nx = cursor;
        gen_nx    = gen_count;
        run_nx    = run_mode;
        pp_nx     = pause_pending;
        settle_nx = settle_cnt;
        restart   = 1'b0;
        still     = 1'b0;
`ifdef LIFE_CTRL_AUTOPAUSE_EN
        stable_nx = stable_r;
`endif
        if (btn_clear) begin
            board_nx  = '0;
            gen_nx    = '0;
            run_nx    = 1'b0;
            pp_nx     = 1'b0;
            settle_nx = '0;
            restart   = 1'b1;
            state_nx  = PAUSED;
`ifdef LIFE_CTRL_AUTOPAUSE_EN
            stable_nx = 1'b0;
`endif
        end else begin
            case (state)
                PAUSED: begin
                    if (btn_run) begin
                        run_nx   = 1'b1;
                        restart  = 1'b1;
                        state_nx = RUN;
                    end else if (btn_step) begin
                        run_nx    = 1'b0;
                        settle_nx = '0;
                        state_nx  = SETTLE;
                    end else if (btn_toggle) begin
                        board_nx[cursor] = ~board_q[cursor];
`ifdef LIFE_CTRL_AUTOPAUSE_EN
                        stable_nx = 1'b0;
`endif
                    end else if (btn_up) begin
                        cursor_nx = cursor_step(cursor, 4'hF, 4'h0);
                    end else if (btn_down) begin
                        cursor_nx = cursor_step(cursor, 4'h1, 4'h0);
                    end else if (btn_left) begin
                        cursor_nx = cursor_step(cursor, 4'h0, 4'hF);
                    end else if (btn_right) begin
                        cursor_nx = cursor_step(cursor, 4'h0, 4'h1);
                    end
                end
                RUN: begin
                    if (btn_run) begin
                        run_nx   = 1'b0;
                        state_nx = PAUSED;
                    end else if (tick) begin
                        settle_nx = '0;
                        state_nx  = SETTLE;
                    end
                end
                SETTLE: begin
                    // A pause request here must not cut the generation short;
                    // it is remembered and honoured at COMMIT.
                    if (btn_run) begin
                        pp_nx = 1'b1;
                    end
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nx = COMMIT;
                    end else begin
                        settle_nx = settle_cnt + SW'(1);
                    end
                end
                COMMIT: begin
`ifdef LIFE_CTRL_AUTOPAUSE_EN
                    still     = (next_board == board_q);
                    stable_nx = still;
`endif
                    board_nx  = next_board;
                    gen_nx    = gen_count + 16'd1;
                    pp_nx     = 1'b0;
                    settle_nx = '0;
                    if (run_mode && !pause_pending && !still) begin
                        state_nx = RUN;
                    end else begin
                        run_nx   = 1'b0;
                        state_nx = PAUSED;
                    end
                end
                default: begin
                    state_nx = PAUSED;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= PAUSED;
            board_q       <= '0;
            cursor        <= '0;
            gen_count     <= '0;
            run_mode      <= 1'b0;
            pause_pending <= 1'b0;
            settle_cnt    <= '0;
        end else begin
            state         <= state_nx;
            board_q       <= board_nx;
            cursor        <= cursor_nx;
            gen_count     <= gen_nx;
            run_mode      <= run_nx;
            pause_pending <= pp_nx;
            settle_cnt    <= settle_nx;
        end
    end

`ifdef LIFE_CTRL_AUTOPAUSE_EN
    // Still-life flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_r <= 1'b0;
        end else begin
            stable_r <= stable_nx;
        end
    end
    assign stable = stable_r;
`else
    assign stable = 1'b0;
`endif

    assign running   = run_mode;
    assign state_dbg = state;

endmodule

// File: tb/tb_life_ctrl.sv
// Testbench for life_ctrl: cycle-level reference model feeding an expected
// queue, a monitor that compares every cycle, plus directed scenario checks.
module tb_life_ctrl;
    import life_pkg::*;

    localparam int TB_TICK   = 4;
    localparam int TB_SETTLE = 2;
    localparam int W         = 282;

    localparam logic [7:0] K_NONE   = 8'h00;
    localparam logic [7:0] K_RIGHT  = 8'h01;
    localparam logic [7:0] K_LEFT   = 8'h02;
    localparam logic [7:0] K_DOWN   = 8'h04;
    localparam logic [7:0] K_UP     = 8'h08;
    localparam logic [7:0] K_TOGGLE = 8'h10;
    localparam logic [7:0] K_STEP   = 8'h20;
    localparam logic [7:0] K_RUN    = 8'h40;
    localparam logic [7:0] K_CLEAR  = 8'h80;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
    logic btn_toggle = 0, btn_step = 0, btn_run = 0, btn_clear = 0;
    logic [255:0] next_board = '0;
    logic [255:0] board_q;
    logic [7:0]   cursor;
    logic         running;
    logic [15:0]  gen_count;
    logic         stable;
    ctrl_state_t  state_dbg;

    life_ctrl #(
        .TICK_DIV      (TB_TICK),
        .SETTLE_CYCLES (TB_SETTLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_toggle (btn_toggle),
        .btn_step   (btn_step),
        .btn_run    (btn_run),
        .btn_clear  (btn_clear),
        .next_board (next_board),
        .board_q    (board_q),
        .cursor     (cursor),
        .running    (running),
        .gen_count  (gen_count),
        .stable     (stable),
        .state_dbg  (state_dbg)
    );

    // Life rule on a 16x16 board with dead cells beyond the edges.
    function automatic logic [255:0] life_next(input logic [255:0] b);
        logic [255:0] n;
        n = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr, cc;
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 16 && cc >= 0 && cc < 16)
                            cnt += int'(b[rr*16+cc]);
                    end
                end
                if (b[r*16+c]) n[r*16+c] = (cnt == 2 || cnt == 3);
                else           n[r*16+c] = (cnt == 3);
            end
        end
        return n;
    endfunction

    // Registered update stage environment.
    always @(posedge clk) next_board <= life_next(board_q);

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A generation in progress is described by how many cycles have elapsed
    // (m_count) and how long it lasts before its commit cycle (m_len); the
    // last TB_SETTLE cycles before the commit are the hold window.
    logic [255:0] m_board;
    int           m_row, m_col;
    logic [15:0]  m_gen;
    bit           m_run, m_pp, m_stable, m_active;
    int           m_count, m_len;

    task automatic model_step(input logic [7:0] b, input bit r);
        logic [255:0] nb;
        bit still;
        if (r) begin
            m_board = '0; m_row = 0; m_col = 0; m_gen = '0;
            m_run = 0; m_pp = 0; m_stable = 0; m_active = 0; m_count = 0; m_len = 0;
        end else if (b[7]) begin
            m_board = '0; m_gen = '0; m_stable = 0; m_run = 0; m_pp = 0; m_active = 0;
        end else if (!m_active) begin
            if (b[6]) begin
                m_run = 1; m_active = 1; m_count = 0; m_len = TB_TICK + TB_SETTLE;
            end else if (b[5]) begin
                m_active = 1; m_count = 0; m_len = TB_SETTLE;
            end else if (b[4]) begin
                m_board[m_row*16+m_col] = ~m_board[m_row*16+m_col];
                m_stable = 0;
            end else if (b[3]) m_row = (m_row + 15) % 16;
            else if (b[2])     m_row = (m_row + 1) % 16;
            else if (b[1])     m_col = (m_col + 15) % 16;
            else if (b[0])     m_col = (m_col + 1) % 16;
        end else if (m_count == m_len) begin
            nb = life_next(m_board);
            still = 0;
`ifdef LIFE_CTRL_AUTOPAUSE_EN
            still = (nb == m_board);
            m_stable = still;
`endif
            m_board = nb;
            m_gen = m_gen + 16'd1;
            if (m_run && !m_pp && !still) begin
                m_count = 0; m_len = TB_TICK + TB_SETTLE;
            end else begin
                m_active = 0; m_run = 0;
            end
            m_pp = 0;
        end else if (m_count < m_len - TB_SETTLE) begin
            if (b[6]) begin
                m_run = 0; m_active = 0;
            end else m_count++;
        end else begin
            if (b[6]) m_pp = 1;
            m_count++;
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic [7:0] b, input bit r = 1'b0);
        @(negedge clk);
        reset      = r;
        btn_right  = b[0];
        btn_left   = b[1];
        btn_down   = b[2];
        btn_up     = b[3];
        btn_toggle = b[4];
        btn_step   = b[5];
        btn_run    = b[6];
        btn_clear  = b[7];
        model_step(b, r);
        exp_q.push_back({m_board, 8'(m_row*16 + m_col), m_run, m_gen, m_stable});
        cyc++;
    endtask

    task automatic wait_gen(input logic [15:0] g, output int at);
        int n;
        n = 0;
        while (gen_count !== g && n < 60) begin
            cycle(K_NONE);
            n++;
        end
        at = cyc;
        check("wait_gen", 256'(gen_count), 256'(g));
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("board_q",   board_q,           e[281:26]);
            check("cursor",    256'(cursor),      256'(e[25:18]));
            check("running",   256'(running),     256'(e[17]));
            check("gen_count", 256'(gen_count),   256'(e[16:1]));
            check("stable",    256'(stable),      256'(e[0]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] blinker_h, blinker_v;
        int t1, t2;
        logic [7:0] b;
        int p;

        blinker_h = '0; blinker_h[17] = 1'b1; blinker_h[18] = 1'b1; blinker_h[19] = 1'b1;
        blinker_v = '0; blinker_v[2]  = 1'b1; blinker_v[18] = 1'b1; blinker_v[34] = 1'b1;

        repeat (3) cycle(K_NONE, 1'b1);
        cycle(K_NONE);

        // Cursor wrap on both axes.
        cycle(K_LEFT);  cycle(K_NONE); check("wrap_left",  256'(cursor), 256'(15));
        cycle(K_UP);    cycle(K_NONE); check("wrap_up",    256'(cursor), 256'(255));
        cycle(K_RIGHT); cycle(K_NONE); check("wrap_right", 256'(cursor), 256'(240));
        cycle(K_DOWN);  cycle(K_NONE); check("wrap_down",  256'(cursor), 256'(0));

        // Blinker run: two generations, 7-cycle period.
        cycle(K_DOWN); cycle(K_RIGHT); cycle(K_TOGGLE);
        cycle(K_RIGHT); cycle(K_TOGGLE);
        cycle(K_RIGHT); cycle(K_TOGGLE);
        cycle(K_NONE);
        check("blinker_init", board_q, blinker_h);
        cycle(K_RUN);
        wait_gen(16'd1, t1);
        check("blinker_gen1", board_q, blinker_v);
        check("blinker_running", 256'(running), 256'(1));
        wait_gen(16'd2, t2);
        check("blinker_gen2", board_q, blinker_h);
        check("blinker_period", 256'(t2 - t1), 256'(TB_TICK + TB_SETTLE + 1));
        cycle(K_CLEAR); cycle(K_NONE);
        check("clear_board", board_q, 256'(0));
        check("clear_gen", 256'(gen_count), 256'(0));

        // Step with a simultaneous toggle: toggle dropped, new board 4 cycles on.
        cycle(K_TOGGLE); cycle(K_LEFT); cycle(K_TOGGLE); cycle(K_LEFT); cycle(K_TOGGLE);
        cycle(K_STEP | K_TOGGLE);
        repeat (3) cycle(K_NONE);
        check("step_hold", board_q, blinker_h);
        cycle(K_NONE);
        check("step_new", board_q, blinker_v);
        check("step_gen", 256'(gen_count), 256'(1));
        check("step_paused", 256'(running), 256'(0));

        // Pause request during SETTLE still lets the generation commit.
        cycle(K_RUN);
        repeat (5) cycle(K_NONE);
        check("in_settle", 256'(state_dbg), 256'(SETTLE));
        cycle(K_RUN);
        repeat (4) cycle(K_NONE);
        check("pp_running", 256'(running), 256'(0));
        check("pp_gen", 256'(gen_count), 256'(2));
        check("pp_board", board_q, blinker_h);

        // Clear in the middle of a run.
        cycle(K_RUN); cycle(K_NONE); cycle(K_NONE);
        cycle(K_CLEAR); cycle(K_NONE);
        check("clr_run_board", board_q, 256'(0));
        check("clr_run_gen", 256'(gen_count), 256'(0));
        check("clr_run_running", 256'(running), 256'(0));
        check("clr_run_state", 256'(state_dbg), 256'(PAUSED));

        // Reset while SETTLE is in progress.
        cycle(K_TOGGLE); cycle(K_STEP); cycle(K_NONE);
        cycle(K_NONE, 1'b1);
        cycle(K_NONE);
        check("rst_board", board_q, 256'(0));
        check("rst_cursor", 256'(cursor), 256'(0));
        check("rst_gen", 256'(gen_count), 256'(0));
        check("rst_state", 256'(state_dbg), 256'(PAUSED));

`ifdef LIFE_CTRL_AUTOPAUSE_EN
        // 2x2 block is a still life: first commit pauses and flags it.
        cycle(K_DOWN); cycle(K_RIGHT); cycle(K_TOGGLE);
        cycle(K_RIGHT); cycle(K_TOGGLE);
        cycle(K_DOWN); cycle(K_TOGGLE);
        cycle(K_LEFT); cycle(K_TOGGLE);
        cycle(K_RUN);
        wait_gen(16'd1, t1);
        check("auto_stable", 256'(stable), 256'(1));
        check("auto_running", 256'(running), 256'(0));
        cycle(K_TOGGLE); cycle(K_NONE);
        check("auto_toggle_clr", 256'(stable), 256'(0));
`endif

        // Randomized phase, checked cycle by cycle against the model.
        cycle(K_CLEAR);
        for (int i = 0; i < 3000; i++) begin
            p = $urandom_range(0, 99);
            if (p < 65) b = K_NONE;
            else if (p < 66) b = K_CLEAR;
            else begin
                b = 8'(1) << $urandom_range(0, 6);
                if ($urandom_range(0, 4) == 0) b = b | (8'(1) << $urandom_range(0, 6));
            end
            cycle(b, $urandom_range(0, 999) == 0);
        end
        cycle(K_NONE);

        @(posedge clk);
        #2;
        check("queue_drain", 256'(exp_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
